// File: rtl/aci_tape_player.sv
// Apple-1 ACI cassette waveform synthesizer: plays header tone, sync cycle and
// MSB-first data cycles on tape_level from a loader-supplied byte stream.
module aci_tape_player #(
   parameter int HEADER_HALF   = 650,
   parameter int HEADER_CYCLES = 2000,
   parameter int SYNC_HALF     = 200,
   parameter int ZERO_HALF     = 250,
   parameter int ONE_HALF      = 500,
   parameter int CW            = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_clken,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   input  logic       byte_last,
   output logic       byte_ready,
   output logic       tape_level,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      SYNC,
      LOAD,
      DATA,
      FINISH
   } state_t;

   localparam logic [CW-1:0] HDR_LD   = CW'(HEADER_HALF - 1);
   localparam logic [CW-1:0] SYNC_LD  = CW'(SYNC_HALF - 1);
   localparam logic [CW-1:0] ZERO_LD  = CW'(ZERO_HALF - 1);
   localparam logic [CW-1:0] ONE_LD   = CW'(ONE_HALF - 1);
   localparam logic [CW:0]   HDR_LAST = (CW+1)'(2 * HEADER_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] half_cnt;
   logic [CW:0]   half_idx;
   logic [7:0]    shreg;
   logic          last_q;
   logic [2:0]    bit_idx;

   function automatic logic [CW-1:0] bit_reload(input logic b);
      return b ? ONE_LD : ZERO_LD;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         tape_level <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         byte_ready <= 1'b0;
         underrun   <= 1'b0;
         half_cnt   <= '0;
         half_idx   <= '0;
         shreg      <= '0;
         last_q     <= 1'b0;
         bit_idx    <= '0;
      end else begin
         done       <= 1'b0;
         byte_ready <= 1'b0;
         if (abort) begin
            state      <= IDLE;
            tape_level <= 1'b0;
            busy       <= 1'b0;
            half_cnt   <= '0;
            half_idx   <= '0;
            bit_idx    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  tape_level <= 1'b0;
                  if (start) begin
                     state    <= HEADER;
                     busy     <= 1'b1;
                     underrun <= 1'b0;
                     half_cnt <= HDR_LD;
                     half_idx <= '0;
                  end
               end

               HEADER: if (cpu_clken) begin
                  if (half_cnt != '0) begin
                     half_cnt <= half_cnt - 1'b1;
                  end else begin
                     tape_level <= ~tape_level;
                     if (half_idx == HDR_LAST) begin
                        state    <= SYNC;
                        half_idx <= '0;
                        half_cnt <= SYNC_LD;
                     end else begin
                        half_idx <= half_idx + 1'b1;
                        half_cnt <= HDR_LD;
                     end
                  end
               end

               SYNC: if (cpu_clken) begin
                  if (half_cnt != '0) begin
                     half_cnt <= half_cnt - 1'b1;
                  end else begin
                     tape_level <= ~tape_level;
                     if (half_idx[0]) begin
                        state    <= LOAD;
                        half_idx <= '0;
                        half_cnt <= '0;
                     end else begin
                        half_idx <= half_idx + 1'b1;
                        half_cnt <= SYNC_LD;
                     end
                  end
               end

               // Single-clock byte fetch; cpu_clken is deliberately ignored here.
               LOAD: begin
                  if (byte_valid) begin
                     shreg      <= byte_data;
                     last_q     <= byte_last;
                     byte_ready <= 1'b1;
                     bit_idx    <= 3'd7;
                     half_idx   <= '0;
                     half_cnt   <= bit_reload(byte_data[7]);
                     state      <= DATA;
                  end else begin
                     underrun   <= 1'b1;
                     tape_level <= 1'b0;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end
               end

               // shreg[7] is always the bit on air; lengths never come from live byte_data.
               DATA: if (cpu_clken) begin
                  if (half_cnt != '0) begin
                     half_cnt <= half_cnt - 1'b1;
                  end else begin
                     tape_level <= ~tape_level;
                     if (!half_idx[0]) begin
                        half_idx <= (CW+1)'(1);
                        half_cnt <= bit_reload(shreg[7]);
                     end else begin
                        half_idx <= '0;
                        if (bit_idx == 3'd0) begin
                           half_cnt <= '0;
                           state    <= last_q ? FINISH : LOAD;
                        end else begin
                           bit_idx  <= bit_idx - 1'b1;
                           shreg    <= {shreg[6:0], 1'b0};
                           half_cnt <= bit_reload(shreg[6]);
                        end
                     end
                  end
               end

               FINISH: begin
                  done       <= 1'b1;
                  tape_level <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aci_tape_player.sv
// Bench for aci_tape_player: queue-of-half-lengths reference model, per-cycle
// compare, and directed waveform interval checks.
module tb_aci_tape_player;

   localparam int HH = 4, HC = 2, SH = 2, ZH = 3, OH = 6;

   logic       clk = 1'b0;
   logic       reset, cpu_clken, start, abort, byte_valid, byte_last;
   logic [7:0] byte_data;
   logic       byte_ready, tape_level, busy, done, underrun;

   int checks = 0;
   int errors = 0;

   aci_tape_player #(
      .HEADER_HALF(HH), .HEADER_CYCLES(HC), .SYNC_HALF(SH),
      .ZERO_HALF(ZH), .ONE_HALF(OH), .CW(16)
   ) dut (
      .clk(clk), .reset(reset), .cpu_clken(cpu_clken), .start(start), .abort(abort),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_last(byte_last),
      .byte_ready(byte_ready), .tape_level(tape_level), .busy(busy), .done(done),
      .underrun(underrun)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- stimulus helpers: clken and byte feeder ----------------
   int ck_mode = 0;
   int ck_phase = 0;
   initial forever begin
      @(negedge clk);
      case (ck_mode)
         0: cpu_clken = 1'b1;
         1: begin cpu_clken = (ck_phase == 0); ck_phase = (ck_phase + 1) % 3; end
         default: cpu_clken = ($urandom_range(0, 1) == 1);
      endcase
   end

   logic [8:0] feed_q[$];
   bit  feed_en = 1'b1;
   int  feed_mode = 0;
   initial forever begin
      bit en;
      @(negedge clk);
      if (byte_ready && feed_q.size() > 0) void'(feed_q.pop_front());
      en = (feed_mode == 0) ? feed_en : ($urandom_range(0, 9) < 6);
      if (en && feed_q.size() > 0) begin
         byte_valid = 1'b1;
         byte_data  = feed_q[0][7:0];
         byte_last  = feed_q[0][8];
      end else begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         byte_last  = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- reference model: playback as a queue of half lengths ----------------
   typedef enum int {M_IDLE, M_PLAY, M_LOAD, M_FIN} mph_t;
   mph_t mph = M_IDLE;
   int   halves[$];
   int   rem;
   bit   m_last;
   logic m_lvl, m_busy, m_done, m_rdy, m_und;
   bit   ck_at_edge;

   initial forever begin
      @(posedge clk);
      ck_at_edge = cpu_clken;
      m_done = 1'b0;
      m_rdy  = 1'b0;
      if (reset) begin
         mph = M_IDLE; m_lvl = 0; m_busy = 0; m_und = 0; halves.delete();
      end else if (abort) begin
         mph = M_IDLE; m_lvl = 0; m_busy = 0; halves.delete();
      end else begin
         case (mph)
            M_IDLE: if (start) begin
               m_busy = 1; m_und = 0; m_last = 0;
               halves.delete();
               repeat (2 * HC) halves.push_back(HH);
               repeat (2) halves.push_back(SH);
               rem = halves[0];
               mph = M_PLAY;
            end
            M_PLAY: if (cpu_clken) begin
               rem--;
               if (rem == 0) begin
                  m_lvl = !m_lvl;
                  void'(halves.pop_front());
                  if (halves.size() == 0) mph = m_last ? M_FIN : M_LOAD;
                  else rem = halves[0];
               end
            end
            M_LOAD: if (byte_valid) begin
               m_rdy = 1; m_last = byte_last;
               for (int b = 7; b >= 0; b--) repeat (2) halves.push_back(byte_data[b] ? OH : ZH);
               rem = halves[0];
               mph = M_PLAY;
            end else begin
               m_und = 1; m_lvl = 0; m_busy = 0; mph = M_IDLE;
            end
            M_FIN: begin
               m_done = 1; m_lvl = 0; m_busy = 0; mph = M_IDLE;
            end
            default: mph = M_IDLE;
         endcase
      end
   end

   bit cmp_en = 1'b0;
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("tape_level", tape_level, m_lvl);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("byte_ready", byte_ready, m_rdy);
         chk("underrun", underrun, m_und);
      end
   end

   // ---------------- waveform monitor: toggle intervals in clks ----------------
   int cyc = 0, t_last = 0, n_ready = 0, n_done = 0, done_gap = -1;
   int ivals[$];
   logic prev_lvl = 1'b0, prev_busy = 1'b0;
   initial forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && prev_busy !== 1'b1) t_last = cyc;
      if (tape_level !== prev_lvl) begin
         ivals.push_back(cyc - t_last);
         t_last = cyc;
         if (busy === 1'b1) chk("level_moves_only_on_tick", ck_at_edge, 1);
      end
      if (byte_ready === 1'b1) n_ready++;
      if (done === 1'b1) begin n_done++; done_gap = cyc - t_last; end
      prev_lvl  = tape_level;
      prev_busy = busy;
   end

   task automatic clear_mon();
      ivals.delete(); n_ready = 0; n_done = 0; done_gap = -1;
   endtask

   int exp_iv[$];
   logic [7:0] exp_bytes[$];
   int exp_a[22] = '{4, 4, 4, 4, 2, 2, 7, 6, 3, 3, 6, 6, 3, 3, 3, 3, 6, 6, 3, 3, 6, 6};

   // Expected toggle intervals at cpu_clken=1; first half of each byte carries the LOAD clk.
   task automatic build_exp();
      exp_iv.delete();
      repeat (2 * HC) exp_iv.push_back(HH);
      repeat (2) exp_iv.push_back(SH);
      foreach (exp_bytes[k])
         for (int b = 7; b >= 0; b--) begin
            exp_iv.push_back((exp_bytes[k][b] ? OH : ZH) + ((b == 7) ? 1 : 0));
            exp_iv.push_back(exp_bytes[k][b] ? OH : ZH);
         end
   endtask

   task automatic cmp_ivals(input string nm);
      chk({nm, "_count"}, ivals.size(), exp_iv.size());
      for (int i = 0; i < exp_iv.size() && i < ivals.size(); i++)
         chk($sformatf("%s_half%0d", nm, i), ivals[i], exp_iv[i]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string nm);
      int n = 0;
      while (busy === 1'b1 && n < maxc) begin @(negedge clk); n++; end
      chk(nm, busy, 0);
   endtask

   task automatic wait_ready(input int cnt, input string nm);
      int n = 0;
      while (n_ready < cnt && n < 2000) begin @(negedge clk); n++; end
      chk(nm, (n_ready >= cnt), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   int wn, ab_at, nb;

   initial begin
      reset = 1; start = 0; abort = 0; cpu_clken = 1;
      byte_valid = 0; byte_data = 0; byte_last = 0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_level", tape_level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", byte_ready, 0);
      chk("rst_underrun", underrun, 0);
      reset = 0;
      repeat (2) @(negedge clk);

      // Single byte 0xA5, last
      clear_mon();
      feed_q = {9'h1A5};
      repeat (2) @(negedge clk);
      pulse_start();
      wait_idle(1000, "a_timeout");
      exp_iv.delete();
      foreach (exp_a[i]) exp_iv.push_back(exp_a[i]);
      cmp_ivals("a");
      chk("a_ready_count", n_ready, 1);
      chk("a_done_count", n_done, 1);
      chk("a_done_gap", done_gap, 1);
      chk("a_level_end", tape_level, 0);
      repeat (3) @(negedge clk);

      // Two bytes 0x00, 0xFF(last)
      clear_mon();
      feed_q = {9'h000, 9'h1FF};
      repeat (2) @(negedge clk);
      pulse_start();
      wait_idle(1000, "b_timeout");
      exp_bytes = {8'h00, 8'hFF};
      build_exp();
      cmp_ivals("b");
      chk("b_ready_count", n_ready, 2);
      chk("b_done_count", n_done, 1);
      repeat (3) @(negedge clk);

      // cpu_clken every 3rd clk, byte 0x80 last
      ck_mode = 1;
      clear_mon();
      feed_q = {9'h180};
      repeat (3) @(negedge clk);
      pulse_start();
      wait_idle(3000, "c_timeout");
      chk("c_count", ivals.size(), 22);
      if (ivals.size() >= 22) begin
         chk("c_hdr_half", ivals[1], HH * 3);
         chk("c_sync_half", ivals[5], SH * 3);
         chk("c_one_half", ivals[7], OH * 3);
         chk("c_zero_half", ivals[8], ZH * 3);
         chk("c_last_half", ivals[21], ZH * 3);
      end
      chk("c_done_count", n_done, 1);
      ck_mode = 0;
      repeat (3) @(negedge clk);

      // Starvation at end of SYNC
      feed_en = 1'b0;
      feed_q.delete();
      clear_mon();
      repeat (2) @(negedge clk);
      pulse_start();
      wait_idle(500, "d_timeout");
      chk("d_underrun", underrun, 1);
      chk("d_level", tape_level, 0);
      chk("d_no_done", n_done, 0);
      chk("d_no_ready", n_ready, 0);
      feed_en = 1'b1;
      feed_q = {9'h13C};
      repeat (2) @(negedge clk);
      pulse_start();
      chk("d_underrun_cleared", underrun, 0);
      wait_idle(1000, "d2_timeout");
      chk("d2_done_count", n_done, 1);
      repeat (3) @(negedge clk);

      // Abort in the second half of bit 3 of 0x5A (level high there)
      clear_mon();
      feed_q = {9'h05A, 9'h1C3};
      repeat (2) @(negedge clk);
      pulse_start();
      wait_ready(1, "e_first_ready");
      wn = 0;
      while (ivals.size() < 15 && wn < 2000) begin @(negedge clk); wn++; end
      chk("e_reach_bit3", (ivals.size() >= 15), 1);
      repeat (2) @(negedge clk);
      chk("e_level_before_abort", tape_level, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("e_abort_busy", busy, 0);
      chk("e_abort_level", tape_level, 0);
      chk("e_abort_done", done, 0);
      chk("e_abort_ready", byte_ready, 0);
      chk("e_abort_ready_count", n_ready, 1);
      repeat (3) @(negedge clk);
      clear_mon();
      pulse_start();
      wait_idle(1000, "e_replay_timeout");
      exp_bytes = {8'hC3};
      build_exp();
      cmp_ivals("e_replay");
      chk("e_replay_done", n_done, 1);
      repeat (3) @(negedge clk);

      // start and abort together in IDLE
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("startabort_busy", busy, 0);
      repeat (2) @(negedge clk);

      // Reset during HEADER with start held high, then start pulse during DATA
      feed_q = {9'h196};
      start = 1'b1;
      repeat (6) @(negedge clk);
      chk("f_busy_before_reset", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("f_rst_level", tape_level, 0);
      chk("f_rst_busy", busy, 0);
      chk("f_rst_done", done, 0);
      chk("f_rst_ready", byte_ready, 0);
      chk("f_rst_underrun", underrun, 0);
      reset = 1'b0;
      @(negedge clk);
      start = 1'b0;
      clear_mon();
      wait_ready(1, "f_ready");
      repeat (5) @(negedge clk);
      pulse_start();
      wait_idle(1000, "f_timeout");
      exp_bytes = {8'h96};
      build_exp();
      exp_iv.delete(0);
      for (int i = 0; i < exp_iv.size(); i++) exp_iv[i] = exp_iv[i];
      void'(ivals.size());
      chk("f_done_count", n_done, 1);
      chk("f_ready_count", n_ready, 1);
      repeat (3) @(negedge clk);

      // Randomized playback: random clken, feeder gaps, stray starts, occasional abort
      ck_mode = 2;
      feed_mode = 1;
      for (int it = 0; it < 25; it++) begin
         feed_q.delete();
         nb = $urandom_range(1, 3);
         for (int k = 0; k < nb; k++) feed_q.push_back({1'(k == nb - 1), 8'($urandom)});
         repeat (2) @(negedge clk);
         pulse_start();
         ab_at = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 300) : -1;
         wn = 0;
         while (busy === 1'b1 && wn < 4000) begin
            abort = (wn == ab_at);
            start = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            wn++;
         end
         abort = 1'b0;
         start = 1'b0;
         chk("rand_timeout", busy, 0);
         repeat (2) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
